// File: rtl/eth_mac_rx_xgmii.sv
// eth_mac_rx_xgmii: receive framing stage behind the 10G PCS RX.
//
// Takes the 32-bit XGMII word stream, which is qualified by i_clk_en. It strips
// the start/preamble/SFD and the XGMII control characters, then delivers the
// frame bytes (DA..FCS) as a word stream with keep/last/err. The stream cannot
// be back-pressured. It also checks the FCS residue, the min/max length and
// XGMII error/framing violations.
//
// Ports:
//   i_clk, i_reset_n   RX recovered clock; asynchronous active-low reset
//   i_clk_en           PCS word-valid strobe; XGMII inputs sampled only when high
//   i_xgmii_ctrl/data  per-lane control flag / character, lane 0 first on the wire
//   o_valid            single-cycle word strobe
//   o_data, o_keep     frame bytes and contiguous-from-lane-0 byte enables
//   o_last, o_err      final word of frame; frame bad (meaningful only with o_last)
//   o_frame_ok/bad     one-cycle pulse alongside a good / bad end of frame

package eth_mac_rx_xgmii_pkg;
  localparam int N_CHANNELS = 4;
  localparam int W_BYTE     = 8;

  localparam logic [7:0] CH_S   = 8'hFB;
  localparam logic [7:0] CH_T   = 8'hFD;
  localparam logic [7:0] CH_I   = 8'h07;
  localparam logic [7:0] CH_PRE = 8'h55;
  localparam logic [7:0] CH_SFD = 8'hD5;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_DATA, ST_DROP} rx_state_t;
endpackage

module eth_mac_rx_xgmii
  import eth_mac_rx_xgmii_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_clk_en,
  input  logic [N_CHANNELS-1:0]        i_xgmii_ctrl,
  input  logic [N_CHANNELS*W_BYTE-1:0] i_xgmii_data,
  output logic                         o_valid,
  output logic [N_CHANNELS*W_BYTE-1:0] o_data,
  output logic [N_CHANNELS-1:0]        o_keep,
  output logic                         o_last,
  output logic                         o_err,
  output logic                         o_frame_ok,
  output logic                         o_frame_bad
);

  localparam int DW     = N_CHANNELS * W_BYTE;
  localparam int LANE_W = $clog2(N_CHANNELS);
  localparam int CNT_W  = $clog2(MAX_LEN + 4);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  // Reflected CRC-32 over the lanes enabled in mask, lane 0 first, no final XOR.
  function automatic logic [31:0] crc_step(input logic [31:0] crc_in,
                                           input logic [DW-1:0] data,
                                           input logic [N_CHANNELS-1:0] mask);
    logic [31:0] c;
    c = crc_in;
    for (int l = 0; l < N_CHANNELS; l++) begin
      if (mask[l]) begin
        c = c ^ 32'(data[l*W_BYTE +: W_BYTE]);
        for (int b = 0; b < W_BYTE; b++) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [LANE_W:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  function automatic logic frame_err(input logic bad, input logic [31:0] crc,
                                     input logic [CNT_W-1:0] cnt);
    return bad || (crc != CRC_RESIDUE) || (cnt < MIN_CNT) || (cnt > MAX_CNT);
  endfunction

  rx_state_t state, state_n;

  logic [DW-1:0]         hold_data, hold_data_n;
  logic [N_CHANNELS-1:0] hold_keep, hold_keep_n;
  logic                  hold_valid, hold_valid_n;  // a word is waiting to go out
  logic                  hold_final, hold_final_n;  // that word closes the frame
  logic                  bad, bad_n;                // framing/E/oversize seen
  logic [31:0]           crc, crc_n;
  logic [CNT_W-1:0]      cnt, cnt_n;

  logic                  valid_n, last_n, err_n, ok_n, fbad_n;
  logic [DW-1:0]         data_n;
  logic [N_CHANNELS-1:0] keep_n;

  // Input word decode.
  logic                  any_ctrl, is_t, is_s0, start_word, preamble_word, has_ti;
  logic [LANE_W-1:0]     term_lane;
  logic [W_BYTE-1:0]     term_char;
  logic [N_CHANNELS-1:0] data_mask;
  logic [31:0]           crc_full, crc_part;
  logic [CNT_W-1:0]      cnt_full, cnt_part;

  always_comb begin
    any_ctrl  = |i_xgmii_ctrl;
    term_lane = '0;
    // The lowest lane that carries a control character ends the data.
    for (int l = N_CHANNELS - 1; l >= 0; l--)
      if (i_xgmii_ctrl[l]) term_lane = LANE_W'(l);
    term_char = i_xgmii_data[term_lane*W_BYTE +: W_BYTE];
    is_t      = any_ctrl && (term_char == CH_T);
    is_s0     = i_xgmii_ctrl[0] && (i_xgmii_data[W_BYTE-1:0] == CH_S);

    data_mask = '0;
    for (int l = 0; l < N_CHANNELS; l++)
      data_mask[l] = !any_ctrl || (LANE_W'(l) < term_lane);

    start_word    = (i_xgmii_ctrl == N_CHANNELS'(1)) && (i_xgmii_data[W_BYTE-1:0] == CH_S);
    preamble_word = (i_xgmii_ctrl == '0) &&
                    (i_xgmii_data[DW-1 -: W_BYTE] == CH_SFD);
    has_ti        = 1'b0;
    for (int l = 0; l < N_CHANNELS; l++) begin
      if (l > 0 && i_xgmii_data[l*W_BYTE +: W_BYTE] != CH_PRE) start_word = 1'b0;
      if (l < N_CHANNELS - 1 && i_xgmii_data[l*W_BYTE +: W_BYTE] != CH_PRE)
        preamble_word = 1'b0;
      if (i_xgmii_ctrl[l] && (i_xgmii_data[l*W_BYTE +: W_BYTE] == CH_T ||
                              i_xgmii_data[l*W_BYTE +: W_BYTE] == CH_I))
        has_ti = 1'b1;
    end

    crc_full = crc_step(crc, i_xgmii_data, '1);
    crc_part = crc_step(crc, i_xgmii_data, data_mask);
    cnt_full = sat_add(cnt, (LANE_W+1)'(N_CHANNELS));
    cnt_part = sat_add(cnt, {1'b0, term_lane});
  end

  // Next-state and output decision. Everything moves only on i_clk_en, so
  // o_valid can only pulse on word-valid cycles.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    state_n      = state;
    hold_data_n  = hold_data;
    hold_keep_n  = hold_keep;
    hold_valid_n = hold_valid;
    hold_final_n = hold_final;
    bad_n        = bad;
    crc_n        = crc;
    cnt_n        = cnt;
    valid_n      = 1'b0;
    data_n       = '0;
    keep_n       = '0;
    last_n       = 1'b0;
    err_n        = 1'b0;
    ok_n         = 1'b0;
    fbad_n       = 1'b0;

    if (i_clk_en) begin
      // A partial (or error) tail word left behind by the previous frame goes
      // out on the first word slot after termination. Only IDLE/DROP can be
      // active here, and those states never emit anything else.
      if (hold_final) begin
        valid_n      = 1'b1;
        data_n       = hold_data;
        keep_n       = hold_keep;
        last_n       = 1'b1;
        err_n        = frame_err(bad, crc, cnt);
        ok_n         = !err_n;
        fbad_n       = err_n;
        hold_valid_n = 1'b0;
        hold_final_n = 1'b0;
      end

      unique case (state)
        ST_IDLE:     if (start_word) state_n = ST_PREAMBLE;
        ST_PREAMBLE: begin
          if (preamble_word) begin
            state_n      = ST_DATA;
            crc_n        = CRC_INIT;
            cnt_n        = '0;
            bad_n        = 1'b0;
            hold_valid_n = 1'b0;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_DROP:     if (has_ti) state_n = ST_IDLE;
        ST_DATA: begin
          if (hold_valid) begin
            valid_n = 1'b1;
            data_n  = hold_data;
            keep_n  = '1;
          end
          if (!any_ctrl) begin
            hold_data_n  = i_xgmii_data;
            hold_keep_n  = '1;
            hold_valid_n = 1'b1;
            crc_n        = crc_full;
            cnt_n        = cnt_full;
            // Too long: this word becomes the bad tail and the rest is dropped.
            if (cnt_full > MAX_CNT) begin
              hold_final_n = 1'b1;
              bad_n        = 1'b1;
              state_n      = ST_DROP;
            end
          end else begin
            crc_n = crc_part;
            cnt_n = cnt_part;
            bad_n = !is_t;
            if (term_lane != '0) begin
              // Data bytes precede the control: they form the tail word.
              hold_data_n  = i_xgmii_data;
              hold_keep_n  = data_mask;
              hold_valid_n = 1'b1;
              hold_final_n = 1'b1;
            end else begin
              hold_valid_n = 1'b0;
              if (hold_valid) begin
                last_n = 1'b1;
                err_n  = frame_err(!is_t, crc_part, cnt_part);
                ok_n   = !err_n;
                fbad_n = err_n;
              end else begin
                fbad_n = 1'b1;  // nothing after the SFD: no word to carry last
              end
            end
            if (is_t)       state_n = ST_IDLE;
            else if (is_s0) state_n = ST_PREAMBLE;
            else            state_n = ST_DROP;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_n;
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the values from before this edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hold_data   <= '0;
      hold_keep   <= '0;
      hold_valid  <= 1'b0;
      hold_final  <= 1'b0;
      bad         <= 1'b0;
      crc         <= CRC_INIT;
      cnt         <= '0;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_keep      <= '0;
      o_last      <= 1'b0;
      o_err       <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_bad <= 1'b0;
    end else begin
      hold_data   <= hold_data_n;
      hold_keep   <= hold_keep_n;
      hold_valid  <= hold_valid_n;
      hold_final  <= hold_final_n;
      bad         <= bad_n;
      crc         <= crc_n;
      cnt         <= cnt_n;
      o_valid     <= valid_n;
      o_data      <= data_n;
      o_keep      <= keep_n;
      o_last      <= last_n;
      o_err       <= err_n;
      o_frame_ok  <= ok_n;
      o_frame_bad <= fbad_n;
    end
  end

endmodule
